// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
//
// Turns the byte stream from an SPI slave bridge into register-bus accesses.
// The first byte of a chip-select window is a command:
//   bit7      : 1 = write, 0 = read
//   bit6      : reserved, ignored
//   bits[5:0] : register address
// A write command is followed by one data byte, which is issued with a
// one-cycle reg_write strobe. A read command issues a one-cycle reg_read
// strobe and loads the returned data into data_out for the bridge to shift
// out on the next transfer.
//
// byte_sync and cs_n come from the sclk domain. Each passes through its own
// SYNC_STAGES-flop synchronizer. A rising edge of the synchronized chip select
// ends the transaction and aborts any half-finished write.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cs_n       in   SPI chip select (async, active low)
//   byte_sync  in   byte-complete flag from the bridge (sclk domain)
//   data_in    in   [7:0] received byte, stable while byte_sync is high
//   data_out   out  [7:0] byte offered to the bridge for the next transmit
//   reg_addr   out  [5:0] register address
//   reg_wdata  out  [7:0] register write data
//   reg_write  out  one-cycle write strobe
//   reg_read   out  one-cycle read strobe
//   reg_rdata  in   [7:0] register read data, sampled in the reg_read cycle
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module spi_cmd_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       byte_sync,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    output logic       reg_read,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD_WR  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // -------------------------------------------------------------------------
    // Synchronizers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bs_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   bs_prev_reg;
    logic                   cs_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bs_sync_reg <= '0;
            cs_sync_reg <= '1;   // chip select idles deasserted
            bs_prev_reg <= 1'b0;
            cs_prev_reg <= 1'b1;
        end else begin
            bs_sync_reg <= {bs_sync_reg[SYNC_STAGES-2:0], byte_sync};
            cs_sync_reg <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            bs_prev_reg <= bs_sync_reg[SYNC_STAGES-1];
            cs_prev_reg <= cs_sync_reg[SYNC_STAGES-1];
        end
    end

    logic bs_synced;
    logic cs_high;
    logic byte_valid;
    logic cs_rise;

    assign bs_synced  = bs_sync_reg[SYNC_STAGES-1];
    assign cs_high    = cs_sync_reg[SYNC_STAGES-1];
    assign byte_valid = bs_synced & ~bs_prev_reg;
    assign cs_rise    = cs_high & ~cs_prev_reg;

    // -------------------------------------------------------------------------
    // Captured byte and deferred command
    // -------------------------------------------------------------------------
    // byte_reg keeps the last received byte. If a byte lands while the FSM is
    // in RD_WAIT, pend_reg marks it so IDLE decodes it from byte_reg on the
    // next cycle instead of losing it.
    logic [7:0] byte_reg;
    logic       pend_reg, pend_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_reg <= 8'h00;
        end else if (byte_valid) begin
            byte_reg <= data_in;
        end
    end

    // Any byte seen while chip select is high is discarded. Because cs_rise
    // implies cs_high, this also makes an abort win over a coincident byte.
    logic       cmd_valid;
    logic [7:0] cmd_byte;

    assign cmd_valid = (byte_valid | pend_reg) & ~cs_high;
    assign cmd_byte  = pend_reg ? byte_reg : data_in;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        state_next = cmd_byte[7] ? CMD_WR : RD_WAIT;
                    end
                end
                CMD_WR: begin
                    if (cmd_valid) begin
                        state_next = IDLE;
                    end
                end
                RD_WAIT: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    logic [7:0] data_out_reg,  data_out_next;
    logic [5:0] reg_addr_reg,  reg_addr_next;
    logic [7:0] reg_wdata_reg, reg_wdata_next;
    logic       reg_write_reg, reg_write_next;
    logic       reg_read_reg,  reg_read_next;

    always_comb begin
        data_out_next  = data_out_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        reg_write_next = 1'b0;
        reg_read_next  = 1'b0;
        pend_next      = 1'b0;

        // reg_read is high during RD_WAIT, so reg_rdata is valid here. The
        // strobe has already been issued, so the data is kept even if the
        // window closes in this cycle.
        if (state_reg == RD_WAIT) begin
            data_out_next = reg_rdata;
        end

        if (!cs_rise) begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        reg_addr_next = cmd_byte[5:0];
                        reg_read_next = ~cmd_byte[7];
                    end
                end
                CMD_WR: begin
                    if (cmd_valid) begin
                        reg_wdata_next = cmd_byte;
                        reg_write_next = 1'b1;
                    end
                end
                RD_WAIT: begin
                    pend_next = cmd_valid;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg  <= 8'h00;
            reg_addr_reg  <= 6'd0;
            reg_wdata_reg <= 8'h00;
            reg_write_reg <= 1'b0;
            reg_read_reg  <= 1'b0;
            pend_reg      <= 1'b0;
        end else begin
            data_out_reg  <= data_out_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_write_reg <= reg_write_next;
            reg_read_reg  <= reg_read_next;
            pend_reg      <= pend_next;
        end
    end

    assign data_out  = data_out_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_write = reg_write_reg;
    assign reg_read  = reg_read_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_decoder
//
// Directed bench for spi_cmd_decoder. Expected register strobes (kind,
// address, data and the cycle they must appear in) are queued when a byte is
// driven; every clock tick pops and compares any strobe the DUT produces.
// -----------------------------------------------------------------------------
module tb_spi_cmd_decoder;

    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;
    logic       busy;

    spi_cmd_decoder #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .byte_sync (byte_sync),
        .data_in   (data_in),
        .data_out  (data_out),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_write;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge and score any strobe.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        check("no_overlap", {31'd0, reg_write & reg_read}, 32'd0);
        if (reg_write || reg_read) begin
            check("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("cyc %0d: %s addr=%0h wdata=%0h", cyc,
                         reg_write ? "WRITE" : "READ", reg_addr, reg_wdata);
                check("strobe_kind", {31'd0, reg_write}, {31'd0, e.is_write});
                check("strobe_addr", {26'd0, reg_addr}, {26'd0, e.addr});
                check("strobe_cycle", cyc, e.cyc);
                if (e.is_write) begin
                    check("strobe_wdata", {24'd0, reg_wdata}, {24'd0, e.wdata});
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        data_in   = b;
        byte_sync = 1'b1;
    endtask

    task automatic release_byte();
        byte_sync = 1'b0;
        ticks(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_byte(b);
        ticks(S + 3);
        release_byte();
    endtask

    // Strobe appears S+1 ticks after the byte is driven.
    task automatic expect_write(input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.is_write = 1'b1; e.addr = a; e.wdata = d; e.cyc = cyc + S + 1;
        sb.push_back(e);
    endtask

    task automatic expect_read(input logic [5:0] a);
        exp_t e;
        e.is_write = 1'b0; e.addr = a; e.wdata = 8'h00; e.cyc = cyc + S + 1;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},  {24'd0, data_out},  32'd0);
        check({tag, "_reg_addr"},  {26'd0, reg_addr},  32'd0);
        check({tag, "_reg_wdata"}, {24'd0, reg_wdata}, 32'd0);
        check({tag, "_reg_write"}, {31'd0, reg_write}, 32'd0);
        check({tag, "_reg_read"},  {31'd0, reg_read},  32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        cs_n      = 1'b1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        reg_rdata = 8'h00;

        // Reset state
        ticks(3);
        check_reset_outputs("rst_during");
        rst = 1'b0;
        ticks(2);
        check_reset_outputs("rst_after");

        // Open a chip-select window
        cs_n = 1'b0;
        ticks(S + 2);

        // Write 0x3C to 0x05
        send_byte(8'h85);
        check("wr_busy_cmd", {31'd0, busy}, 32'd1);
        expect_write(6'h05, 8'h3C);
        send_byte(8'h3C);
        check("wr_busy_done", {31'd0, busy}, 32'd0);
        check("wr_wdata_held", {24'd0, reg_wdata}, 32'h3C);

        // Read 0x12 returning 0xA7, data_out timing and hold after cs_n high
        reg_rdata = 8'hA7;
        expect_read(6'h12);
        drive_byte(8'h12);
        ticks(S + 1);
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_dout_early", {24'd0, data_out}, 32'h00);
        tick();
        check("rd_dout", {24'd0, data_out}, 32'hA7);
        check("rd_busy_done", {31'd0, busy}, 32'd0);
        release_byte();
        reg_rdata = 8'h00;
        cs_n = 1'b1;
        ticks(S + 4);
        check("rd_dout_hold", {24'd0, data_out}, 32'hA7);

        // Byte while cs_n high is ignored
        send_byte(8'h03);
        check("cs_high_busy", {31'd0, busy}, 32'd0);
        check("cs_high_addr", {26'd0, reg_addr}, 32'h12);

        // Abort: write command then cs_n high, next byte is a fresh read
        cs_n = 1'b0;
        ticks(S + 2);
        send_byte(8'h81);
        check("abort_busy_cmd", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        ticks(S + 3);
        check("abort_busy", {31'd0, busy}, 32'd0);
        cs_n = 1'b0;
        ticks(S + 2);
        reg_rdata = 8'h5A;
        expect_read(6'h02);
        send_byte(8'h02);
        check("abort_next_dout", {24'd0, data_out}, 32'h5A);

        // Back-to-back read then write in one window
        reg_rdata = 8'hC3;
        expect_read(6'h01);
        send_byte(8'h01);
        check("b2b_dout", {24'd0, data_out}, 32'hC3);
        send_byte(8'h90);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        expect_write(6'h10, 8'h55);
        send_byte(8'h55);
        check("b2b_busy_done", {31'd0, busy}, 32'd0);

        // Reset in CMD_WR, then a normal write
        send_byte(8'h8F);
        check("rstwr_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rstwr");
        ticks(S + 2);
        check("rstwr_busy_after", {31'd0, busy}, 32'd0);
        send_byte(8'h8F);
        expect_write(6'h0F, 8'h11);
        send_byte(8'h11);

        // Collision: cs_n rise together with the data byte
        send_byte(8'h81);
        check("coll_busy_cmd", {31'd0, busy}, 32'd1);
        drive_byte(8'h77);
        cs_n = 1'b1;
        ticks(S + 3);
        release_byte();
        check("coll_busy", {31'd0, busy}, 32'd0);
        check("coll_wdata", {24'd0, reg_wdata}, 32'h11);
        cs_n = 1'b0;
        ticks(S + 4);

        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
